// File: rtl/sm_collector.sv
// sm_collector: capture stage that sits behind the comparator-free sorter.
// Sorted addr/data beats are written into a local buffer while the sorter
// runs. Once the sorter's sticky done rises, the buffer is replayed in
// address order through a valid/ready port. The consumer may apply
// backpressure; this decouples it from the sorter's fixed output rate.
//
// Optional build macro ORDER_CHECK_EN: flags a descending step between two
// consecutive-address captures on order_err_o. When ORDER_CHECK_EN is not
// defined, order_err_o is tied low and no compare logic is built.
//
// Readout handshake: a beat moves when out_valid_o and out_ready_i are both
// high on a rising clk edge. While out_valid_o is high and out_ready_i is low,
// out_data_o and out_last_o hold their values. out_valid_o stays high until
// the beat is accepted.

module sm_collector #(
   parameter int DATA_WIDTH  = 8,
   parameter int ELEMENT_NUM = 16,
   parameter int ADDR_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sm_valid_i,
   input  logic [ADDR_W-1:0]     sm_addr_i,
   input  logic [DATA_WIDTH-1:0] sm_data_i,
   input  logic                  sm_done_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic                  busy_o,
   output logic                  complete_o,
   output logic                  cnt_err_o,
   output logic                  order_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_FINISH  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(ELEMENT_NUM);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ELEMENT_NUM - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t                  state_q, state_d;
   logic [ADDR_W:0]         wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic                    cnt_err_q, cnt_err_d;
   logic                    done_d_q;

   logic [DATA_WIDTH-1:0]   mem_q [ELEMENT_NUM];

   logic                    cap;
   logic                    cap_en;
   logic                    done_rise;
   logic                    xfer;
   logic [ADDR_W-1:0]       rd_next;

   // The final beat repeats while done is high; only beats before done count.
   assign cap       = sm_valid_i & ~sm_done_i;
   assign done_rise = sm_done_i & ~done_d_q;
   // Writes are accepted only before the drain starts, never afterwards.
   assign cap_en    = cap & ((state_q == ST_IDLE) | (state_q == ST_CAPTURE));
   assign xfer      = out_valid_q & out_ready_i;
   assign rd_next   = rd_ptr_q + ADDR_ONE;

   // Control and readout registers; an async reset aborts any batch in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_cnt_q    <= '0;
         rd_ptr_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         cnt_err_q   <= 1'b0;
         done_d_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         cnt_err_q   <= cnt_err_d;
         done_d_q    <= sm_done_i;
      end
   end

   // Element buffer; contents are left as they are on reset.
   always_ff @(posedge clk) begin
      if (cap_en) begin
         mem_q[sm_addr_i] <= sm_data_i;
      end
   end

   // Next-state logic for the FSM, the capture counter and the readout port.
   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      cnt_err_d   = cnt_err_q;

      // Count saturates at a full batch so that extra beats cannot wrap it.
      if (cap_en && (wr_cnt_q != FULL_CNT)) begin
         wr_cnt_d = wr_cnt_q + CNT_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (cap) begin
               state_d = ST_CAPTURE;
            end else if (done_rise) begin
               // The sorter finished without sending a single beat.
               cnt_err_d = 1'b1;
               state_d   = ST_FINISH;
            end
         end
         ST_CAPTURE: begin
            if (done_rise) begin
               rd_ptr_d    = '0;
               out_data_d  = mem_q[0];
               out_valid_d = 1'b1;
               out_last_d  = (ELEMENT_NUM == 1);
               cnt_err_d   = (wr_cnt_q != FULL_CNT);
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (xfer) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = ST_FINISH;
               end else begin
                  rd_ptr_d   = rd_next;
                  out_data_d = mem_q[rd_next];
                  out_last_d = (rd_next == LAST_IDX);
               end
            end
         end
         ST_FINISH: begin
            // Terminal until reset, in step with the sorter's sticky done.
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef ORDER_CHECK_EN
   logic [DATA_WIDTH-1:0] prev_data_q;
   logic [ADDR_W-1:0]     prev_addr_q;
   logic                  prev_vld_q;
   logic                  order_err_q;

   // Track the last capture and flag a descending step between neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_data_q <= '0;
         prev_addr_q <= '0;
         prev_vld_q  <= 1'b0;
         order_err_q <= 1'b0;
      end else if (cap_en) begin
         prev_data_q <= sm_data_i;
         prev_addr_q <= sm_addr_i;
         prev_vld_q  <= 1'b1;
         // Equal values are legal; only a strict decrease is flagged.
         if (prev_vld_q && (sm_addr_i == (prev_addr_q + ADDR_ONE)) &&
             (sm_data_i < prev_data_q)) begin
            order_err_q <= 1'b1;
         end
      end
   end

   assign order_err_o = order_err_q;
`else
   assign order_err_o = 1'b0;
`endif

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;
   assign busy_o      = (state_q == ST_CAPTURE) | (state_q == ST_DRAIN);
   assign complete_o  = (state_q == ST_FINISH);
   assign cnt_err_o   = cnt_err_q;

endmodule

// File: tb/tb_sm_collector.sv
// tb_sm_collector: directed bench for sm_collector.
// It covers these cases:
//   - the reset state
//   - a normal batch with the duplicate last beat
//   - a batch drained under backpressure
//   - a short batch
//   - the order check
//   - a reset during the drain, followed by a fresh batch
// Expected readout values are queued in exp_q and are computed by hand.

module tb_sm_collector;

   localparam int DW = 8;
   localparam int N  = 16;
   localparam int AW = 4;

`ifdef ORDER_CHECK_EN
   localparam logic ORDER_ON = 1'b1;
`else
   localparam logic ORDER_ON = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          sm_valid;
   logic [AW-1:0] sm_addr;
   logic [DW-1:0] sm_data;
   logic          sm_done;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          complete;
   logic          cnt_err;
   logic          order_err;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] exp_q[$];

   sm_collector #(
      .DATA_WIDTH (DW),
      .ELEMENT_NUM(N),
      .ADDR_W     (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sm_valid_i (sm_valid),
      .sm_addr_i  (sm_addr),
      .sm_data_i  (sm_data),
      .sm_done_i  (sm_done),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .out_last_o (out_last),
      .busy_o     (busy),
      .complete_o (complete),
      .cnt_err_o  (cnt_err),
      .order_err_o(order_err)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      rst       = 1'b1;
      sm_valid  = 1'b0;
      sm_addr   = '0;
      sm_data   = '0;
      sm_done   = 1'b0;
      out_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic send_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
      sm_valid = 1'b1;
      sm_addr  = a;
      sm_data  = d;
      tick();
   endtask

   // Raise done and present the duplicate final beat with a bogus value.
   task automatic raise_done();
      sm_done  = 1'b1;
      sm_valid = 1'b1;
      sm_addr  = 4'd15;
      sm_data  = 8'hAA;
      tick();
   endtask

   // Scoreboard drain: stall_mode gives the ready pattern 1,0,0,1,0,0,...
   task automatic drain(input bit stall_mode, input int exp_cycles);
      int            cyc;
      bit            stalled;
      logic [DW-1:0] held_data;
      logic          held_last;
      logic [DW-1:0] want;
      cyc       = 0;
      stalled   = 1'b0;
      held_data = '0;
      held_last = 1'b0;
      while (exp_q.size() > 0 && cyc < 200) begin
         out_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
         check("complete_early", complete, 0);
         if (stalled) begin
            check("hold_data", out_data, held_data);
            check("hold_last", out_last, held_last);
         end
         if (out_valid && out_ready) begin
            want = exp_q.pop_front();
            check("out_data", out_data, want);
            check("out_last", out_last, exp_q.size() == 0);
            stalled = 1'b0;
         end else if (out_valid) begin
            stalled   = 1'b1;
            held_data = out_data;
            held_last = out_last;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      check("drain_cycles", cyc, exp_cycles);
      check("drain_left", exp_q.size(), 0);
      check("end_valid", out_valid, 0);
      check("end_complete", complete, 1);
      check("end_busy", busy, 0);
   endtask

   function automatic logic [DW-1:0] order_data(input int i);
      if (i == 5) return 8'h1F;
      return DW'(i * 8);
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b1;
      sm_valid  = 1'b0;
      sm_addr   = '0;
      sm_data   = '0;
      sm_done   = 1'b0;
      out_ready = 1'b0;

      // Reset state
      apply_reset();
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_complete", complete, 0);
      check("rst_cnt_err", cnt_err, 0);
      check("rst_order_err", order_err, 0);

      // Normal batch: data 2i+3. mem[15] must keep 33 despite the 0xAA duplicate.
      for (int i = 0; i < N; i++) begin
         send_beat(AW'(i), DW'(2 * i + 3));
         if (i == 0) check("cap_busy", busy, 1);
      end
      check("cap_no_valid", out_valid, 0);
      raise_done();
      check("first_valid", out_valid, 1);
      check("norm_cnt_err", cnt_err, 0);
      for (int i = 0; i < N; i++) exp_q.push_back(DW'(2 * i + 3));
      drain(1'b0, 16);
      check("norm_cnt_err_end", cnt_err, 0);
      check("norm_order_err", order_err, 0);
      repeat (3) tick();
      check("finish_hold", complete, 1);
      check("finish_no_valid", out_valid, 0);

      // Backpressure: same batch, ready pattern 1,0,0 -> 16 transfers over 46 cycles
      apply_reset();
      for (int i = 0; i < N; i++) send_beat(AW'(i), DW'(2 * i + 3));
      raise_done();
      for (int i = 0; i < N; i++) exp_q.push_back(DW'(2 * i + 3));
      drain(1'b1, 46);
      check("bp_cnt_err", cnt_err, 0);

      // Short batch: addrs 0..9 = 0x50+i; entries 10..15 still hold 2i+3
      apply_reset();
      for (int i = 0; i < 10; i++) send_beat(AW'(i), DW'(8'h50 + i));
      raise_done();
      check("short_cnt_err", cnt_err, 1);
      for (int i = 0; i < N; i++) exp_q.push_back(i < 10 ? DW'(8'h50 + i) : DW'(2 * i + 3));
      drain(1'b0, 16);
      check("short_cnt_err_end", cnt_err, 1);

      // Order check: addr4=0x20 then addr5=0x1F, then reset mid-drain
      apply_reset();
      for (int i = 0; i < N; i++) begin
         send_beat(AW'(i), order_data(i));
         if (i == 4) check("ord_before", order_err, 0);
         if (i == 5) check("ord_flag", order_err, ORDER_ON);
      end
      raise_done();
      check("ord_sticky", order_err, ORDER_ON);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("mid_valid", out_valid, 1);
         check("mid_data", out_data, order_data(k));
         tick();
      end
      check("mid_busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_valid", out_valid, 0);
      check("async_busy", busy, 0);
      check("async_complete", complete, 0);
      check("async_order_err", order_err, 0);
      sm_done  = 1'b0;
      sm_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("post_rst_valid", out_valid, 0);
      check("post_rst_busy", busy, 0);

      // Fresh batch after the abort drains from index 0
      for (int i = 0; i < N; i++) send_beat(AW'(i), DW'(8'h80 + i));
      raise_done();
      for (int i = 0; i < N; i++) exp_q.push_back(DW'(8'h80 + i));
      drain(1'b0, 16);
      check("fresh_cnt_err", cnt_err, 0);
      check("fresh_order_err", order_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against any unexpected stall of the sequence.
   initial begin
      #200000;
      $display("FAIL timeout: sequence did not finish");
      $fatal(1, "timeout");
   end

endmodule
